// File: rtl/multi_channel_pulse_classifier.sv
// N-channel edge detector and pulse-width classifier with per-channel polarity,
// shared in-range limits and a one-shot over-long flag for runs still in progress.
`timescale 1ns/1ps
module multi_channel_pulse_classifier #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  pol,
  input  logic [CNT_W-1:0] min_len,
  input  logic [CNT_W-1:0] max_len,
  input  logic [N_CH-1:0]  a,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic [N_CH-1:0]  pulse_ok,
  output logic [N_CH-1:0]  pulse_long
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  a_r;
  logic [N_CH-1:0]  pol_r;
  logic [CNT_W-1:0] cnt      [N_CH];
  logic [CNT_W-1:0] cnt_next [N_CH];

  logic [N_CH-1:0]  act;
  logic [N_CH-1:0]  act_r;
  logic [N_CH-1:0]  pol_chg;
  logic [CNT_W-1:0] min_eff;
  logic             live;

  // Outputs are gated by rst as well, so they read 0 throughout reset even
  // though they are combinational from the live input.
  assign live    = rst & en;
  assign act     = a ^ pol;
  assign act_r   = a_r ^ pol;
  assign pol_chg = pol ^ pol_r;
  assign min_eff = (min_len == '0) ? CNT_W'(1) : min_len;

  assign rise = {N_CH{live}} & a & ~a_r;
  assign fall = {N_CH{live}} & ~a & a_r;

  // NOTE: every output of this block gets a default before the loop; a path
  // that skipped an assignment would otherwise infer a latch.
  always_comb begin
    pulse_ok   = '0;
    pulse_long = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = '0;
      if (live && !pol_chg[i]) begin
        pulse_ok[i]   = act_r[i] & ~act[i] & (cnt[i] >= min_eff) & (cnt[i] <= max_len);
        pulse_long[i] = act[i] & (cnt[i] == max_len) & (max_len != CNT_MAX);
      end
      // Run length saturates so an arbitrarily long pulse still reads CNT_MAX at its end.
      if (en && !pol_chg[i] && act[i])
        cnt_next[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers
  // update together from the pre-edge values.
  // NOTE: the counter array is reset explicitly; a stale count surviving
  // reset would classify a phantom pulse after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r   <= '0;
      pol_r <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      a_r   <= a;
      pol_r <= pol;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_multi_channel_pulse_classifier.sv
// Directed-vector bench: stimulus pushes hand-derived expected outputs into a
// queue; a monitor pops and compares one entry per cycle on the falling edge.
`timescale 1ns/1ps
module tb_multi_channel_pulse_classifier;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] pol;
  logic [7:0] min_len;
  logic [7:0] max_len;
  logic [3:0] a;
  logic [3:0] rise, fall, pulse_ok, pulse_long;

  typedef struct {
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] o;
    logic [3:0] l;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  multi_channel_pulse_classifier #(.N_CH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pol        (pol),
    .min_len    (min_len),
    .max_len    (max_len),
    .a          (a),
    .rise       (rise),
    .fall       (fall),
    .pulse_ok   (pulse_ok),
    .pulse_long (pulse_long)
  );

  task automatic push(input logic [3:0] er, ef, eo, el, input string tag);
    exp_t e;
    e.r = er; e.f = ef; e.o = eo; e.l = el; e.tag = tag;
    q.push_back(e);
  endtask

  // One clock cycle of stimulus plus the outputs expected within that cycle.
  task automatic step(input logic [3:0] av, pv, input logic ev,
                      input logic [3:0] er, ef, eo, el, input string tag);
    @(posedge clk); #1;
    a = av; pol = pv; en = ev;
    push(er, ef, eo, el, tag);
  endtask

  // Monitor: combinational outputs are sampled mid-cycle, away from posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (rise !== e.r || fall !== e.f || pulse_ok !== e.o || pulse_long !== e.l) begin
          n_miss++;
          $display("FAIL %s: got rise=%b fall=%b ok=%b long=%b, expected rise=%b fall=%b ok=%b long=%b",
                   e.tag, rise, fall, pulse_ok, pulse_long, e.r, e.f, e.o, e.l);
        end
      end
    end
  end

  logic [15:0] v_a, v_r, v_f, v_o, v_l;
  logic [17:0] w_a, w_r, w_f, w_o, w_l;

  initial begin
    rst = 1'b0; en = 1'b1; pol = 4'h0; a = 4'hF;
    min_len = 8'd1; max_len = 8'd1;

    // Reset state: outputs must stay 0 even with all inputs high.
    repeat (3) begin
      @(posedge clk); #1;
      push(4'h0, 4'h0, 4'h0, 4'h0, "reset_hold");
    end
    @(posedge clk); #1;
    rst = 1'b1; a = 4'h0;
    push(4'h0, 4'h0, 4'h0, 4'h0, "reset_release");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "idle");

    // 1. Legacy single-bit detectors on ch0.
    min_len = 8'd1; max_len = 8'd1;
    v_a = 16'b1001011011110001;
    v_r = 16'b1001010010000001;
    v_f = 16'b0100100100001000;
    v_o = 16'b0100100000000000;
    v_l = 16'b0000001001000000;
    for (int i = 15; i >= 0; i--)
      step({3'b0, v_a[i]}, 4'h0, 1'b1, {3'b0, v_r[i]}, {3'b0, v_f[i]},
           {3'b0, v_o[i]}, {3'b0, v_l[i]}, "legacy");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h1, 4'h1, 4'h0, "legacy_tail");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "legacy_idle");

    // 2. Range [2,3] on ch1 with pulses of length 1,2,3,4.
    min_len = 8'd2; max_len = 8'd3;
    w_a = 18'b100110011100111100;
    w_r = 18'b100100010000100000;
    w_f = 18'b010001000010000010;
    w_o = 18'b000001000010000000;
    w_l = 18'b000000000000000100;
    for (int i = 17; i >= 0; i--)
      step({2'b0, w_a[i], 1'b0}, 4'h0, 1'b1, {2'b0, w_r[i], 1'b0}, {2'b0, w_f[i], 1'b0},
           {2'b0, w_o[i], 1'b0}, {2'b0, w_l[i], 1'b0}, "range_2_3");

    // 3. Low pulse on ch2 with pol[2]=1.
    min_len = 8'd2; max_len = 8'd2;
    step(4'h4, 4'h0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, "pol_idle_high");
    step(4'h4, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "pol_set");
    step(4'h4, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "pol_idle");
    step(4'h0, 4'h4, 1'b1, 4'h0, 4'h4, 4'h0, 4'h0, "low_start");
    step(4'h0, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "low_mid");
    step(4'h4, 4'h4, 1'b1, 4'h4, 4'h0, 4'h4, 4'h0, "low_end_ok");
    step(4'h4, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "pol_idle2");
    step(4'h0, 4'h4, 1'b1, 4'h0, 4'h4, 4'h0, 4'h0, "low_start2");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "pol_restore");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "pol_quiet");

    // 4. Saturation on ch3: over-long flag at high cycle 255, then in-range at CNT_MAX.
    min_len = 8'd1; max_len = 8'd254;
    for (int k = 1; k <= 300; k++)
      step(4'h8, 4'h0, 1'b1, (k == 1) ? 4'h8 : 4'h0, 4'h0, 4'h0,
           (k == 255) ? 4'h8 : 4'h0, "sat_long");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h8, 4'h0, 4'h0, "sat_long_end");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "sat_gap");
    min_len = 8'd255; max_len = 8'd255;
    for (int k = 1; k <= 300; k++)
      step(4'h8, 4'h0, 1'b1, (k == 1) ? 4'h8 : 4'h0, 4'h0, 4'h0, 4'h0, "sat_max");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h8, 4'h8, 4'h0, "sat_max_ok");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "sat_gap2");

    // 5. Reset mid-pulse on ch0 aborts the pulse.
    min_len = 8'd3; max_len = 8'd3;
    step(4'h1, 4'h0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, "rst_pulse_rise");
    step(4'h1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_pulse_hi2");
    step(4'h1, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_pulse_hi3");
    @(posedge clk); #1;
    rst = 1'b0;
    push(4'h0, 4'h0, 4'h0, 4'h0, "rst_mid_pulse");
    @(posedge clk); #1;
    push(4'h0, 4'h0, 4'h0, 4'h0, "rst_mid_hold");
    @(posedge clk); #1;
    rst = 1'b1; a = 4'h0;
    push(4'h0, 4'h0, 4'h0, 4'h0, "rst_release_no_fall");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_after");

    // 6a. en low for 5 cycles across a ch1 pulse; counting restarts at 1.
    min_len = 8'd1; max_len = 8'd3;
    step(4'h2, 4'h0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, "en_rise");
    step(4'h2, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "en_off1");
    step(4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "en_off_fall");
    step(4'h2, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "en_off_rise");
    step(4'h2, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "en_off4");
    step(4'h2, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, "en_off5");
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "en_back_no_edge");
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "en_cnt2");
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "en_cnt3");
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h2, "en_long");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, "en_end_too_long");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "en_idle");

    // 6b. Polarity flip on ch1 in the cycle an over-long flag would fire.
    step(4'h2, 4'h0, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, "flip_rise");
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "flip_hi2");
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "flip_hi3");
    step(4'h0, 4'h2, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, "flip_cycle");
    step(4'h0, 4'h2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "flip_cnt1");
    step(4'h0, 4'h2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "flip_cnt2");
    step(4'h2, 4'h2, 1'b1, 4'h2, 4'h0, 4'h2, 4'h0, "flip_low_ok");
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "unflip_cycle");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, "unflip_fall");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "unflip_idle");

    // All channels coincide.
    min_len = 8'd1; max_len = 8'd1;
    step(4'hF, 4'h0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, "all_rise");
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'hF, 4'hF, 4'h0, "all_fall_ok");

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
